// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle between a producer/consumer pair and sync_fifo_flex.
// master = the side driving requests; slave = the FIFO itself.
interface sync_fifo_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  flush;
  logic                  clr_err;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, flush, clr_err,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, flush, clr_err,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard (1-cycle registered) or FWFT read, occupancy count,
// almost thresholds, sync flush and sticky overflow/underflow; requests beyond full/empty are dropped.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (2**ADDR_WIDTH) - 4,
  parameter int AE_THRESH  = 2
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_flex_if.slave bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_L    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_L    = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_af;
  logic                  r_ae;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ovf_evt;
  logic                  w_unf_evt;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // Acceptance uses the registered flags only, so no input reaches full/empty/count combinationally.
  assign w_wr_acc  = bus.wr_en && !r_full  && !bus.flush;
  assign w_rd_acc  = bus.rd_en && !r_empty && !bus.flush;
  assign w_ovf_evt = bus.wr_en &&  r_full  && !bus.flush;
  assign w_unf_evt = bus.rd_en &&  r_empty && !bus.flush;

  assign w_count_nxt = r_count + (w_wr_acc ? CNT_ONE : '0) - (w_rd_acc ? CNT_ONE : '0);

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_L);
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= AF_L);
      r_ae    <= (w_count_nxt <= AE_L);
    end
  end

  // A fresh error event beats clr_err in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt || (r_ovf && !bus.clr_err);
      r_unf <= w_unf_evt || (r_unf && !bus.clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = r_empty ? '0 : r_mem[r_rd_ptr];
      assign bus.rd_valid = !r_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;
      logic                  r_rvld;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_dout <= '0;
          r_rvld <= 1'b0;
        end else begin
          r_rvld <= w_rd_acc;
          if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
        end
      end

      assign bus.data_out = r_dout;
      assign bus.rd_valid = r_rvld;
    end
  endgenerate

  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_af;
  assign bus.almost_empty = r_ae;
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench: one standard-mode and one FWFT instance, expected values hand-computed.
module tb_sync_fifo_flex;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  sync_fifo_flex_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) s_if ();
  sync_fifo_flex_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) f_if ();

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if.slave)
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u_fw (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (f_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_push(input logic [7:0] d);
    s_if.wr_en   = 1'b1;
    s_if.data_in = d;
    step();
    s_if.wr_en   = 1'b0;
  endtask

  task automatic s_pop_chk(input string tag, input logic [7:0] exp);
    s_if.rd_en = 1'b1;
    step();
    s_if.rd_en = 1'b0;
    check_eq({tag, "_vld"}, 32'(s_if.rd_valid), 32'd1);
    check_eq({tag, "_dat"}, 32'(s_if.data_out), 32'(exp));
  endtask

  task automatic check_std_reset(input string tag);
    check_eq({tag, "_count"}, 32'(s_if.count),        32'd0);
    check_eq({tag, "_empty"}, 32'(s_if.empty),        32'd1);
    check_eq({tag, "_full"},  32'(s_if.full),         32'd0);
    check_eq({tag, "_ae"},    32'(s_if.almost_empty), 32'd1);
    check_eq({tag, "_af"},    32'(s_if.almost_full),  32'd0);
    check_eq({tag, "_dout"},  32'(s_if.data_out),     32'd0);
    check_eq({tag, "_rvld"},  32'(s_if.rd_valid),     32'd0);
    check_eq({tag, "_ovf"},   32'(s_if.overflow),     32'd0);
    check_eq({tag, "_unf"},   32'(s_if.underflow),    32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    s_if.wr_en = 1'b0; s_if.data_in = '0; s_if.rd_en = 1'b0; s_if.flush = 1'b0; s_if.clr_err = 1'b0;
    f_if.wr_en = 1'b0; f_if.data_in = '0; f_if.rd_en = 1'b0; f_if.flush = 1'b0; f_if.clr_err = 1'b0;
    step();
    step();
    check_std_reset("rst");
    check_eq("fw_rst_empty", 32'(f_if.empty),    32'd1);
    check_eq("fw_rst_rvld",  32'(f_if.rd_valid), 32'd0);
    rst_n = 1'b1;
    step();

    // Fill 0x01..0x10; almost_full from count 12, full at 16.
    for (int i = 0; i < 16; i++) begin
      s_push(8'(i + 1));
      check_eq($sformatf("fill_cnt%0d", i), 32'(s_if.count),       32'(i + 1));
      check_eq($sformatf("fill_af%0d", i),  32'(s_if.almost_full), 32'((i + 1) >= 12));
      check_eq($sformatf("fill_full%0d", i), 32'(s_if.full),       32'((i + 1) == 16));
    end
    for (int i = 0; i < 16; i++) begin
      s_pop_chk($sformatf("drain%0d", i), 8'(i + 1));
      check_eq($sformatf("drain_cnt%0d", i), 32'(s_if.count), 32'(15 - i));
    end
    check_eq("drain_empty", 32'(s_if.empty), 32'd1);
    step();
    check_eq("idle_rvld", 32'(s_if.rd_valid), 32'd0);
    check_eq("idle_hold", 32'(s_if.data_out), 32'h10);

    // Full FIFO with simultaneous read/write: write dropped, overflow set.
    for (int i = 0; i < 16; i++) s_push(8'(8'h30 + i));
    check_eq("ovf_pre_full", 32'(s_if.full), 32'd1);
    s_if.wr_en = 1'b1; s_if.rd_en = 1'b1; s_if.data_in = 8'hEE;
    step();
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
    check_eq("ovf_cnt",  32'(s_if.count),    32'd15);
    check_eq("ovf_flag", 32'(s_if.overflow), 32'd1);
    check_eq("ovf_dat",  32'(s_if.data_out), 32'h30);
    check_eq("ovf_full", 32'(s_if.full),     32'd0);
    s_if.clr_err = 1'b1;
    step();
    s_if.clr_err = 1'b0;
    check_eq("ovf_clr", 32'(s_if.overflow), 32'd0);
    for (int i = 1; i < 16; i++) s_pop_chk($sformatf("ovf_rd%0d", i), 8'(8'h30 + i));
    check_eq("ovf_end_empty", 32'(s_if.empty), 32'd1);

    // Underflow: lone read on empty, then read+write on empty.
    s_if.rd_en = 1'b1;
    step();
    s_if.rd_en = 1'b0;
    check_eq("unf_flag", 32'(s_if.underflow), 32'd1);
    check_eq("unf_cnt",  32'(s_if.count),     32'd0);
    check_eq("unf_rvld", 32'(s_if.rd_valid),  32'd0);
    s_if.rd_en = 1'b1; s_if.wr_en = 1'b1; s_if.data_in = 8'hA5;
    step();
    s_if.rd_en = 1'b0; s_if.wr_en = 1'b0;
    check_eq("unf_wr_cnt",  32'(s_if.count),     32'd1);
    check_eq("unf_wr_flag", 32'(s_if.underflow), 32'd1);
    check_eq("unf_wr_rvld", 32'(s_if.rd_valid),  32'd0);
    s_pop_chk("unf_a5", 8'hA5);
    s_if.clr_err = 1'b1;
    step();
    s_if.clr_err = 1'b0;
    check_eq("unf_clr", 32'(s_if.underflow), 32'd0);

    // Wrap: pointers start at 1, so 10 + 12 writes cross index 15.
    for (int i = 0; i < 10; i++) s_push(8'(8'h10 + i));
    for (int i = 0; i < 10; i++) s_pop_chk($sformatf("wrapA%0d", i), 8'(8'h10 + i));
    for (int i = 0; i < 12; i++) s_push(8'(8'h20 + i));
    check_eq("wrap_cnt", 32'(s_if.count), 32'd12);
    check_eq("wrap_af",  32'(s_if.almost_full), 32'd1);
    for (int i = 0; i < 12; i++) s_pop_chk($sformatf("wrapB%0d", i), 8'(8'h20 + i));
    check_eq("wrap_empty", 32'(s_if.empty), 32'd1);

    // Flush with coincident requests: contents gone, no error, data_out held.
    for (int i = 0; i < 7; i++) s_push(8'(8'h40 + i));
    check_eq("fl_pre_cnt", 32'(s_if.count), 32'd7);
    s_if.flush = 1'b1; s_if.wr_en = 1'b1; s_if.rd_en = 1'b1; s_if.data_in = 8'h77;
    step();
    s_if.flush = 1'b0; s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
    check_eq("fl_cnt",   32'(s_if.count),        32'd0);
    check_eq("fl_empty", 32'(s_if.empty),        32'd1);
    check_eq("fl_ae",    32'(s_if.almost_empty), 32'd1);
    check_eq("fl_ovf",   32'(s_if.overflow),     32'd0);
    check_eq("fl_unf",   32'(s_if.underflow),    32'd0);
    check_eq("fl_rvld",  32'(s_if.rd_valid),     32'd0);
    check_eq("fl_hold",  32'(s_if.data_out),     32'h2B);
    s_push(8'h61);
    s_pop_chk("fl_fresh", 8'h61);

    // Reset mid-stream overrides an active write.
    s_push(8'h62);
    s_push(8'h63);
    s_if.wr_en = 1'b1; s_if.rd_en = 1'b1; s_if.data_in = 8'h64;
    rst_n = 1'b0;
    step();
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
    check_std_reset("mid_rst");
    rst_n = 1'b1;
    step();

    // FWFT: written word visible next cycle without rd_en; pop advances.
    f_if.wr_en = 1'b1; f_if.data_in = 8'h55;
    step();
    f_if.wr_en = 1'b0;
    check_eq("fw_empty", 32'(f_if.empty),    32'd0);
    check_eq("fw_rvld",  32'(f_if.rd_valid), 32'd1);
    check_eq("fw_dat",   32'(f_if.data_out), 32'h55);
    f_if.wr_en = 1'b1; f_if.data_in = 8'h66;
    step();
    f_if.wr_en = 1'b0;
    check_eq("fw_head_hold", 32'(f_if.data_out), 32'h55);
    check_eq("fw_cnt2",      32'(f_if.count),    32'd2);
    f_if.rd_en = 1'b1;
    step();
    f_if.rd_en = 1'b0;
    check_eq("fw_next",  32'(f_if.data_out), 32'h66);
    check_eq("fw_cnt1",  32'(f_if.count),    32'd1);
    f_if.rd_en = 1'b1;
    step();
    f_if.rd_en = 1'b0;
    check_eq("fw_pop_empty", 32'(f_if.empty),     32'd1);
    check_eq("fw_pop_rvld",  32'(f_if.rd_valid),  32'd0);
    check_eq("fw_no_unf",    32'(f_if.underflow), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Single-clock parametrised FIFO, the synchronous successor to the team's async FIFO, for same-domain buffering between pipeline stages. Adds:
- selectable standard or first-word-fall-through (FWFT) read mode
- occupancy count
- almost-full/almost-empty thresholds
- synchronous flush
- sticky overflow/underflow error flags, replacing bench-only assertions with hardware status

Parameters:
DATA_WIDTH, 8, payload width in bits
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH (legal 1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (legal 0..DEPTH-1)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
wr_en  in  1  write request
data_in  in  DATA_WIDTH  write data
rd_en  in  1  read/pop request
data_out  out  DATA_WIDTH  read data
rd_valid  out  1  standard mode: data_out updated this cycle; FWFT mode: equals !empty
flush  in  1  synchronous clear of contents
clr_err  in  1  clears sticky error flags
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n=0 at clk edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, data_out=0, rd_valid=0, overflow=0, underflow=0. Memory contents are not reset. Reset overrides all other inputs. Reset mid-transfer discards all stored data.
- Pointers are ADDR_WIDTH bits and wrap naturally at DEPTH. Occupancy is tracked in the count register, not by pointer comparison.
- Write accepted iff wr_en && !full: mem[wr_ptr] <= data_in, wr_ptr++.
- Read accepted iff rd_en && !empty: rd_ptr++.
- count next = count + wr_acc - rd_acc. Simultaneous accepted read and write leaves count unchanged.
- Full with wr_en && rd_en: read accepted, write dropped, overflow set. No pass-through.
- Empty with wr_en && rd_en: write accepted, read rejected, underflow set.
- Flags full, empty, almost_full and almost_empty are registered and consistent with count in the same cycle, i.e. they update on the edge after the causing event.
- Standard mode (FWFT=0):
  - On an accepted read, data_out <= mem[rd_ptr] at that edge, and rd_valid=1 for the following cycle.
  - Otherwise data_out holds its value and rd_valid=0.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - data_out continuously presents mem[rd_ptr]; rd_valid = !empty.
  - A write into an empty FIFO is visible on data_out, with empty=0, in the cycle after the write edge.
  - rd_en acts as pop/acknowledge; the next entry appears the cycle after the pop.
  - data_out is don't-care while empty.
- flush=1: wr_ptr=rd_ptr=0, count=0, and all flags go to their reset values except overflow/underflow, which are retained.
  - flush takes priority over wr_en and rd_en in that cycle; no error flags are set by a request coinciding with flush.
  - Standard mode: data_out holds and rd_valid=0.
- overflow <= 1 when wr_en && full && !flush. underflow <= 1 when rd_en && empty && !flush.
  - Both hold until clr_err=1 or reset.
  - A new error event in the same cycle as clr_err wins, so the flag stays 1.
- No combinational path from inputs to full/empty/count. The only combinational paths are to data_out and rd_valid, in FWFT mode only.

Test Plan:
- DATA_WIDTH=8, ADDR_WIDTH=4, FWFT=0: release reset, write 0x01..0x10 on 16 consecutive cycles. Required: full=1 after the 16th edge, count=16, almost_full=1 from count=12. Then read 16 times. Required: data_out=0x01..0x10 in order, each with rd_valid=1 one cycle after its rd_en, and empty=1 at the end.
- Full FIFO, wr_en=1 and rd_en=1 for 1 cycle. Required: count 16->15, overflow=1, dropped word never appears. Then clr_err=1. Required: overflow=0 next cycle.
- Empty FIFO, rd_en=1 alone. Required: underflow=1, count stays 0, rd_valid=0. Then rd_en=1 with wr_en=1 (data 0xA5) on an empty FIFO. Required: count=1, underflow stays 1.
- Wrap: write 10, read 10, then write 12 (0x20..0x2B) and read 12. Required: pointers wrap past 15 and data returns 0x20..0x2B intact.
- FWFT=1: write 0x55 into an empty FIFO. Required: next cycle empty=0, rd_valid=1, data_out=0x55 with no rd_en. Then pop with rd_en. Required: empty=1 next cycle.
- Load 7 entries, assert flush together with wr_en and rd_en. Required: next cycle count=0, empty=1, almost_empty=1, no error flag set. Then drive rst_n=0 mid-stream. Required: all outputs at their reset values next edge.
